// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel synchronizer and stability filter, one-cycle
// edge pulses, mode-gated events, sticky flags with interrupt, and a saturating event counter.

module edge_lane #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(FILTER_LEN) + 1;

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_out;
    logic                   lvl;
    logic [CW-1:0]          cnt;

    assign sync_out = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
            lvl  <= 1'b0;
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
            rise <= 1'b0;
            fall <= 1'b0;
            // Any sample that agrees with the accepted level restarts the persistence count.
            if (sync_out == lvl) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                lvl  <= sync_out;
                cnt  <= '0;
                rise <= sync_out;
                fall <= ~sync_out;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module multi_edge_detector #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   in,
    input  logic [2*WIDTH-1:0] mode,
    input  logic [WIDTH-1:0]   clear,
    input  logic               count_clr,
    output logic [WIDTH-1:0]   rising_edge,
    output logic [WIDTH-1:0]   falling_edge,
    output logic [WIDTH-1:0]   qual_event,
    output logic [WIDTH-1:0]   sticky,
    output logic               irq,
    output logic [CNT_W-1:0]   event_count
);
    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        edge_lane #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILTER_LEN (FILTER_LEN)
        ) u_lane (
            .clk  (clk),
            .reset(reset),
            .din  (in[g]),
            .rise (rising_edge[g]),
            .fall (falling_edge[g])
        );
        // Named qual_event because "event" is a reserved word; mode gates it combinationally.
        assign qual_event[g] = (rising_edge[g] & mode[2*g]) | (falling_edge[g] & mode[2*g+1]);
    end

    assign irq = |sticky;

    logic [CNT_W:0] pop;
    logic [CNT_W:0] sum;

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) pop = pop + (CNT_W+1)'(qual_event[i]);
        sum = (count_clr ? '0 : {1'b0, event_count}) + pop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky      <= '0;
            event_count <= '0;
        end else begin
            sticky      <= qual_event | (sticky & ~clear);
            event_count <= (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
        end
    end
endmodule

// File: tb/tb_multi_edge_detector.sv
// Randomised and directed bench for multi_edge_detector against a window-based reference model.

module tb_multi_edge_detector;
    localparam int W  = 4;
    localparam int S  = 2;
    localparam int F  = 3;
    localparam int CW = 8;
    localparam int OW = 4*W + 1 + CW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  in = '0;
    logic [2*W-1:0] mode = '0;
    logic [W-1:0]  clear = '0;
    logic          count_clr = 1'b0;
    logic [W-1:0]  rising_edge, falling_edge, qual_event, sticky;
    logic          irq;
    logic [CW-1:0] event_count;

    int compares = 0;
    int fails = 0;

    multi_edge_detector #(.WIDTH(W), .SYNC_STAGES(S), .FILTER_LEN(F), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in(in), .mode(mode), .clear(clear), .count_clr(count_clr),
        .rising_edge(rising_edge), .falling_edge(falling_edge), .qual_event(qual_event),
        .sticky(sticky), .irq(irq), .event_count(event_count)
    );

    always #5 clk = ~clk;

    // Reference: a level is accepted once the last F synchronized samples all disagree with it.
    logic [W-1:0] m_dly [S];
    logic [W-1:0] m_win [F];
    logic [W-1:0] m_lvl = '0, m_rise = '0, m_fall = '0, m_sticky = '0;
    int           m_count = 0;

    function automatic logic [W-1:0] m_ev();
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = (m_rise[i] & mode[2*i]) | (m_fall[i] & mode[2*i+1]);
        return r;
    endfunction

    function automatic logic [OW-1:0] exp_v();
        return {m_rise, m_fall, m_ev(), m_sticky, |m_sticky, CW'(m_count)};
    endfunction

    function automatic logic [OW-1:0] obs();
        return {rising_edge, falling_edge, qual_event, sticky, irq, event_count};
    endfunction

    task automatic tick();
        logic [W-1:0] ev, seen, flip;
        ev = m_ev();
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < S; k++) m_dly[k] = '0;
            for (int k = 0; k < F; k++) m_win[k] = '0;
            m_lvl = '0; m_rise = '0; m_fall = '0; m_sticky = '0; m_count = 0;
        end else begin
            seen = m_dly[S-1];
            for (int k = S-1; k > 0; k--) m_dly[k] = m_dly[k-1];
            m_dly[0] = in;
            for (int k = F-1; k > 0; k--) m_win[k] = m_win[k-1];
            m_win[0] = seen;
            flip = '1;
            for (int k = 0; k < F; k++) flip = flip & (m_win[k] ^ m_lvl);
            m_rise = flip & ~m_lvl;
            m_fall = flip & m_lvl;
            m_lvl  = m_lvl ^ flip;
            m_sticky = (m_sticky & ~clear) | ev;
            m_count = (count_clr ? 0 : m_count) + $countones(ev);
            if (m_count > (1 << CW) - 1) m_count = (1 << CW) - 1;
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        in = 4'hF; mode = 8'hFF; clear = '0;
        do_reset(2);
        compares++;
        if (obs() !== '0) begin
            fails++; $display("FAIL reset_state got %h want 0", obs());
        end
        in = '0;
        repeat (6) begin
            tick(); compares++;
            if (obs() !== exp_v()) begin fails++; $display("FAIL reset_idle got %h want %h", obs(), exp_v()); end
        end
    endtask

    task automatic test_latency();
        mode = '0;
        in[0] = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick(); compares++;
            if (obs() !== exp_v()) begin fails++; $display("FAIL rise_model t%0d got %h want %h", t, obs(), exp_v()); end
            compares++;
            if (rising_edge !== ((t == 5) ? 4'b0001 : 4'b0000)) begin
                fails++; $display("FAIL rise_latency t%0d got %b want %b", t, rising_edge, (t == 5) ? 4'b0001 : 4'b0000);
            end
        end
        in[0] = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            tick(); compares++;
            if (falling_edge !== ((t == 5) ? 4'b0001 : 4'b0000) || rising_edge !== 4'b0000) begin
                fails++; $display("FAIL fall_latency t%0d got f=%b r=%b want f=%b r=0000", t, falling_edge, rising_edge, (t == 5) ? 4'b0001 : 4'b0000);
            end
        end
    endtask

    task automatic test_glitch();
        int rc, fc;
        logic [CW-1:0] c0;
        do_reset(1);
        mode = 8'hFF;
        for (int len = 2; len <= 3; len++) begin
            rc = 0; fc = 0; c0 = event_count;
            in[1] = 1'b1;
            repeat (len) begin tick(); rc += rising_edge[1]; fc += falling_edge[1]; end
            in[1] = 1'b0;
            repeat (12) begin
                tick(); rc += rising_edge[1]; fc += falling_edge[1];
                compares++;
                if (obs() !== exp_v()) begin fails++; $display("FAIL glitch_model len%0d got %h want %h", len, obs(), exp_v()); end
            end
            compares++;
            if (rc != len - 2 || fc != len - 2) begin
                fails++; $display("FAIL glitch_pulses len%0d got r=%0d f=%0d want %0d", len, rc, fc, len - 2);
            end
            compares++;
            if (event_count !== c0 + CW'(2*(len - 2))) begin
                fails++; $display("FAIL glitch_count len%0d got %0d want %0d", len, event_count, c0 + CW'(2*(len - 2)));
            end
        end
    endtask

    task automatic test_modes();
        logic [1:0] ml [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        int er, ef, rr, ff;
        do_reset(1);
        mode = '0;
        for (int m = 0; m < 4; m++) begin
            mode[5:4] = ml[m];
            er = 0; ef = 0; rr = 0; ff = 0;
            for (int t = 0; t < 16; t++) begin
                in[2] = (t < 8);
                tick();
                rr += rising_edge[2]; ff += falling_edge[2];
                er += qual_event[2] & rising_edge[2];
                ef += qual_event[2] & falling_edge[2];
                compares++;
                if (obs() !== exp_v()) begin fails++; $display("FAIL mode_model m%b got %h want %h", ml[m], obs(), exp_v()); end
            end
            compares++;
            if (er != int'(ml[m][0]) || ef != int'(ml[m][1]) || rr != 1 || ff != 1) begin
                fails++; $display("FAIL mode_gate m%b got ev_r=%0d ev_f=%0d r=%0d f=%0d want %0d %0d 1 1",
                                  ml[m], er, ef, rr, ff, ml[m][0], ml[m][1]);
            end
        end
    endtask

    task automatic test_sticky();
        do_reset(1);
        mode = 8'hFF;
        in[3] = 1'b1;
        repeat (6) tick();
        compares++;
        if (sticky[3] !== 1'b1 || irq !== 1'b1) begin fails++; $display("FAIL sticky_set got s=%b irq=%b want 1 1", sticky[3], irq); end
        clear[3] = 1'b1; tick(); clear[3] = 1'b0;
        compares++;
        if (sticky !== 4'b0000 || irq !== 1'b0) begin fails++; $display("FAIL sticky_clear got s=%b irq=%b want 0000 0", sticky, irq); end
        in[3] = 1'b0;
        repeat (5) tick();
        clear[3] = 1'b1; tick(); clear[3] = 1'b0;
        compares++;
        if (sticky[3] !== 1'b1 || irq !== 1'b1) begin fails++; $display("FAIL sticky_set_wins got s=%b irq=%b want 1 1", sticky[3], irq); end
        compares++;
        if (obs() !== exp_v()) begin fails++; $display("FAIL sticky_model got %h want %h", obs(), exp_v()); end
    endtask

    task automatic test_saturate();
        do_reset(1);
        mode = 8'hFF; in = '0;
        for (int n = 0; n < 63; n++) begin
            in = ~in;
            for (int t = 1; t <= 6; t++) begin
                tick(); compares++;
                if (obs() !== exp_v()) begin fails++; $display("FAIL sat_model n%0d got %h want %h", n, obs(), exp_v()); end
                if (n == 0 && t >= 5) begin
                    compares++;
                    if (event_count !== ((t == 5) ? 8'd0 : 8'd4)) begin
                        fails++; $display("FAIL count_plus4 t%0d got %0d want %0d", t, event_count, (t == 5) ? 0 : 4);
                    end
                end
            end
        end
        in[1:0] = ~in[1:0]; repeat (6) tick();
        compares++;
        if (event_count !== 8'd254) begin fails++; $display("FAIL count_254 got %0d want 254", event_count); end
        in = ~in; repeat (6) tick();
        compares++;
        if (event_count !== 8'd255) begin fails++; $display("FAIL count_sat got %0d want 255", event_count); end
        in = ~in; repeat (6) tick();
        compares++;
        if (event_count !== 8'd255) begin fails++; $display("FAIL count_hold got %0d want 255", event_count); end
        in[1:0] = ~in[1:0]; repeat (5) tick();
        count_clr = 1'b1; tick(); count_clr = 1'b0;
        compares++;
        if (event_count !== 8'd2) begin fails++; $display("FAIL count_clr_load got %0d want 2", event_count); end
    endtask

    task automatic test_reset_mid();
        in = '0;
        do_reset(1);
        repeat (4) tick();
        in[0] = 1'b1;
        repeat (3) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        compares++;
        if (obs() !== '0) begin fails++; $display("FAIL reset_mid got %h want 0", obs()); end
        for (int t = 1; t <= 6; t++) begin
            tick(); compares++;
            if (rising_edge !== ((t == 5) ? 4'b0001 : 4'b0000)) begin
                fails++; $display("FAIL reset_mid_rise t%0d got %b want %b", t, rising_edge, (t == 5) ? 4'b0001 : 4'b0000);
            end
        end
    endtask

    task automatic test_random();
        do_reset(1);
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < W; i++) if ($urandom_range(0, 5) == 0) in[i] = ~in[i];
            if ($urandom_range(0, 15) == 0) mode = 8'($urandom);
            clear     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            count_clr = ($urandom_range(0, 40) == 0);
            reset     = ($urandom_range(0, 300) == 0);
            tick(); compares++;
            if (obs() !== exp_v()) begin fails++; $display("FAIL random_model c%0d got %h want %h", c, obs(), exp_v()); end
        end
        reset = 1'b0; clear = '0; count_clr = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < S; k++) m_dly[k] = '0;
        for (int k = 0; k < F; k++) m_win[k] = '0;
        test_reset();
        test_latency();
        test_glitch();
        test_modes();
        test_sticky();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end
endmodule
